// File: rtl/shift_right_seq_if.sv
// Request/response bundle between the control unit and the sequential right shifter.
interface shift_right_seq_if;
  logic        start;
  logic [15:0] A;
  logic [3:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [15:0] SRResult;

  modport master (
    output start, A, shamt, arith,
    input  busy, done, SRResult
  );

  modport slave (
    input  start, A, shamt, arith,
    output busy, done, SRResult
  );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential 16-bit right shifter (SRL/SRA), one bit position per clock,
// with a start/busy/done handshake and a registered result.
module shift_right_seq (
  input  logic                    Clock,
  input  logic                    Reset,
  shift_right_seq_if.slave        bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] y_q, y_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fill_q, fill_d;
  logic [15:0] result_q, result_d;
  logic [15:0] y_shifted;

  assign y_shifted = {fill_q, y_q[15:1]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      y_q      <= 16'h0000;
      cnt_q    <= 4'd0;
      fill_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          y_d    = bus.A;
          cnt_d  = bus.shamt;
          fill_d = bus.arith & bus.A[15];
          if (bus.shamt != 4'd0) begin
            state_d = StShift;
          end else begin
            // Zero shift: result is the operand itself, skip straight to completion.
            result_d = bus.A;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        y_d   = y_shifted;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d = y_shifted;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.SRResult = result_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: stimulus pushes expected result and
// completion cycle, a negedge monitor pops and compares on every done pulse.
module tb_shift_right_seq;

  logic Clock;
  logic Reset;

  shift_right_seq_if bus ();

  shift_right_seq dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int          n_pass;
  int          n_total;
  int          n_done;

  // Counts rising edges; read #1 after an edge it names the edge just taken.
  initial cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (!Reset && bus.done) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1'b0, int'(bus.SRResult), 0);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.SRResult == e.res, int'(bus.SRResult), int'(e.res));
        check("done_cycle", cyc == e.cyc, int'(cyc), int'(e.cyc));
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [3:0] sh, input logic ar);
    bus.A     = a;
    bus.shamt = sh;
    bus.arith = ar;
    bus.start = 1'b1;
  endtask

  // Counts busy cycles until the block returns to IDLE (bounded).
  task automatic wait_idle(output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (!bus.busy) return;
      nb++;
    end
    check("busy_timeout", 1'b0, nb, 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [3:0] sh, input logic ar,
                        input logic [15:0] exp_res, input string name);
    exp_t e;
    int   nb;
    @(posedge Clock); #1;
    drive(a, sh, ar);
    e.res = exp_res;
    e.cyc = cyc + 1 + int'(sh);
    sb_q.push_back(e);
    @(posedge Clock); #1;
    bus.start = 1'b0;
    wait_idle(nb);
    check({name, "_busy_cycles"}, nb == int'(sh) + 1, nb, int'(sh) + 1);
  endtask

  initial begin
    exp_t e;
    int   nb;
    int   base;
    n_pass  = 0;
    n_total = 0;
    n_done  = 0;
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = 16'h0000;
    bus.shamt = 4'd0;
    bus.arith = 1'b0;
    #2;
    check("reset_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    check("reset_done", bus.done == 1'b0, int'(bus.done), 0);
    check("reset_result", bus.SRResult == 16'h0000, int'(bus.SRResult), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    run_op(16'h8001, 4'd4,  1'b0, 16'h0800, "srl_8001_4");
    run_op(16'h8000, 4'd15, 1'b1, 16'hFFFF, "sra_8000_15");
    run_op(16'h8000, 4'd15, 1'b0, 16'h0001, "srl_8000_15");
    run_op(16'h1234, 4'd0,  1'b0, 16'h1234, "shamt0");
    run_op(16'h7F00, 4'd3,  1'b1, 16'h0FE0, "sra_pos");

    // SRA with operand change and a stray start during SHIFT.
    @(posedge Clock); #1;
    drive(16'hF0F0, 4'd8, 1'b1);
    e.res = 16'hFFF0;
    e.cyc = cyc + 1 + 8;
    sb_q.push_back(e);
    @(posedge Clock); #1;
    bus.start = 1'b0;
    bus.A     = 16'h0000;
    repeat (3) @(posedge Clock);
    #1 bus.start = 1'b1;
    @(posedge Clock); #1;
    bus.start = 1'b0;
    wait_idle(nb);
    repeat (4) @(posedge Clock);
    check("stray_start_dones", n_done == 6, n_done, 6);

    // Reset mid-operation after three shifts.
    @(posedge Clock); #1;
    drive(16'hFFFF, 4'd10, 1'b0);
    @(posedge Clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    check("abort_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    check("abort_done", bus.done == 1'b0, int'(bus.done), 0);
    check("abort_result", bus.SRResult == 16'h0000, int'(bus.SRResult), 0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (12) @(posedge Clock);
    check("abort_no_done", n_done == 6, n_done, 6);
    check("abort_idle", bus.busy == 1'b0, int'(bus.busy), 0);
    run_op(16'h0100, 4'd8, 1'b0, 16'h0001, "after_reset");

    // start held high: accepted every n+2 = 4 edges.
    @(posedge Clock); #1;
    drive(16'h0004, 4'd2, 1'b0);
    base = int'(cyc) + 1;
    for (int i = 0; i < 3; i++) begin
      e.res = 16'h0001;
      e.cyc = base + 4 * i + 2;
      sb_q.push_back(e);
    end
    repeat (9) @(posedge Clock);
    #1 bus.start = 1'b0;
    wait_idle(nb);
    repeat (3) @(posedge Clock);

    check("total_dones", n_done == 10, n_done, 10);
    check("scoreboard_empty", sb_q.size() == 0, sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
